// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared CPU writeback widths and request struct
package wb_arbiter_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int XLEN       = 32;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_req_t;

endpackage

// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - in-order result FIFO with per-entry live bits and rd-match kill
module wb_queue
   import wb_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [REG_ADDR_W-1:0] push_rd,
   input  logic [XLEN-1:0]       push_data,
   input  logic                  pop,
   input  logic                  kill,
   input  logic [REG_ADDR_W-1:0] kill_rd,
   output logic [REG_ADDR_W-1:0] head_rd,
   output logic [XLEN-1:0]       head_data,
   output logic                  head_live,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [REG_ADDR_W-1:0] rd_q   [DEPTH];
   logic [XLEN-1:0]       data_q [DEPTH];
   logic [DEPTH-1:0]      live_q;
   logic [PW-1:0]         head, tail;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign head_rd   = rd_q[head];
   assign head_data = data_q[head];
   assign head_live = live_q[head];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head   <= '0;
         tail   <= '0;
         count  <= '0;
         live_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            rd_q[i]   <= '0;
            data_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (kill && live_q[i] && rd_q[i] == kill_rd)
               live_q[i] <= 1'b0;
         end
         if (pop) begin
            live_q[head] <= 1'b0;
            head         <= nxt(head);
         end
         // A same-cycle kill also covers the entry being written now
         if (push) begin
            rd_q[tail]   <= push_rd;
            data_q[tail] <= push_data;
            live_q[tail] <= !(kill && push_rd == kill_rd);
            tail         <= nxt(tail);
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register file writeback arbiter for pipeline and long-latency results
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   pipe_valid,
   input  logic [4:0]             pipe_rd,
   input  logic [31:0]            pipe_data,
   input  logic                   lu_valid,
   input  logic [4:0]             lu_rd,
   input  logic [31:0]            lu_data,
   output logic                   lu_ready,
   output logic                   regwrite,
   output logic [4:0]             writereg,
   output logic [31:0]            writedata,
   output logic                   wb_stall_req,
   output logic [$clog2(DEPTH):0] q_count
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic                  lu_xfer, q_empty, q_pop, q_push, bypass, kill;
   logic [REG_ADDR_W-1:0] head_rd;
   logic [XLEN-1:0]       head_data;
   logic                  head_live;
   wb_req_t               sel;

   assign lu_ready     = (q_count < CW'(DEPTH));
   assign wb_stall_req = (q_count == CW'(DEPTH));
   assign q_empty      = (q_count == '0);
   assign lu_xfer      = lu_valid && lu_ready;

   // The pipeline never stalls, so it always owns the write port when valid
   assign q_pop  = !pipe_valid && !q_empty;
   assign bypass = !pipe_valid && q_empty && lu_xfer;
   assign q_push = lu_xfer && !bypass;
   assign kill   = pipe_valid && pipe_rd != '0;

   always_comb begin
      sel = '0;
      if (pipe_valid) begin
         sel.valid = 1'b1;
         sel.rd    = pipe_rd;
         sel.data  = pipe_data;
      end else if (q_pop) begin
         sel.valid = head_live;
         sel.rd    = head_rd;
         sel.data  = head_data;
      end else if (bypass) begin
         sel.valid = 1'b1;
         sel.rd    = lu_rd;
         sel.data  = lu_data;
      end
      if (sel.rd == '0)
         sel.valid = 1'b0;
   end

   wb_queue #(.DEPTH(DEPTH)) u_queue (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (q_push),
      .push_rd   (lu_rd),
      .push_data (lu_data),
      .pop       (q_pop),
      .kill      (kill),
      .kill_rd   (pipe_rd),
      .head_rd   (head_rd),
      .head_data (head_data),
      .head_live (head_live),
      .count     (q_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regwrite  <= 1'b0;
         writereg  <= '0;
         writedata <= '0;
      end else begin
         regwrite <= sel.valid;
         if (sel.valid) begin
            writereg  <= sel.rd;
            writedata <= sel.data;
         end
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed self-checking bench for wb_arbiter
module tb_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pipe_valid;
   logic [4:0]  pipe_rd;
   logic [31:0] pipe_data;
   logic        lu_valid;
   logic [4:0]  lu_rd;
   logic [31:0] lu_data;
   logic        lu_ready;
   logic        regwrite;
   logic [4:0]  writereg;
   logic [31:0] writedata;
   logic        wb_stall_req;
   logic [1:0]  q_count;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   wb_arbiter #(.DEPTH(2)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pipe_valid   (pipe_valid),
      .pipe_rd      (pipe_rd),
      .pipe_data    (pipe_data),
      .lu_valid     (lu_valid),
      .lu_rd        (lu_rd),
      .lu_data      (lu_data),
      .lu_ready     (lu_ready),
      .regwrite     (regwrite),
      .writereg     (writereg),
      .writedata    (writedata),
      .wb_stall_req (wb_stall_req),
      .q_count      (q_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pipe(input logic v, input logic [4:0] rd, input logic [31:0] d);
      pipe_valid = v;
      pipe_rd    = rd;
      pipe_data  = d;
   endtask

   task automatic lu(input logic v, input logic [4:0] rd, input logic [31:0] d);
      lu_valid = v;
      lu_rd    = rd;
      lu_data  = d;
   endtask

   initial begin
      rst_n = 1'b0;
      pipe(0, 0, 0);
      lu(0, 0, 0);
      #2;
      check("rst_regwrite", regwrite, 0);
      check("rst_writereg", writereg, 0);
      check("rst_writedata", writedata, 0);
      check("rst_q_count", q_count, 0);
      check("rst_lu_ready", lu_ready, 1);
      check("rst_stall", wb_stall_req, 0);
      step();
      rst_n = 1'b1;
      step();

      // pipeline only
      pipe(1, 5, 32'h1234);
      step();
      pipe(0, 0, 0);
      check("pipe_regwrite", regwrite, 1);
      check("pipe_writereg", writereg, 5);
      check("pipe_writedata", writedata, 32'h1234);
      check("pipe_q_count", q_count, 0);
      step();
      check("idle_regwrite", regwrite, 0);
      check("idle_hold_reg", writereg, 5);

      // LU bypass
      lu(1, 7, 32'hDEAD);
      check("byp_lu_ready", lu_ready, 1);
      step();
      lu(0, 0, 0);
      check("byp_regwrite", regwrite, 1);
      check("byp_writereg", writereg, 7);
      check("byp_writedata", writedata, 32'hDEAD);
      check("byp_q_count", q_count, 0);

      // contention and fill
      pipe(1, 1, 32'h11);
      lu(1, 8, 32'h88);
      step();
      pipe(1, 2, 32'h22);
      lu(1, 9, 32'h99);
      check("fill1_q_count", q_count, 1);
      check("fill1_writereg", writereg, 1);
      check("fill1_lu_ready", lu_ready, 1);
      step();
      lu(0, 0, 0);
      pipe(1, 3, 32'h33);
      check("fill2_q_count", q_count, 2);
      check("fill2_lu_ready", lu_ready, 0);
      check("fill2_stall", wb_stall_req, 1);
      check("fill2_writereg", writereg, 2);
      step();
      pipe(0, 0, 0);
      check("stalled_q_count", q_count, 2);
      check("stalled_writereg", writereg, 3);
      step();
      check("drain1_regwrite", regwrite, 1);
      check("drain1_writereg", writereg, 8);
      check("drain1_writedata", writedata, 32'h88);
      check("drain1_q_count", q_count, 1);
      check("drain1_stall", wb_stall_req, 0);
      check("drain1_lu_ready", lu_ready, 1);
      step();
      check("drain2_writereg", writereg, 9);
      check("drain2_writedata", writedata, 32'h99);
      check("drain2_q_count", q_count, 0);
      step();
      check("drain_idle_regwrite", regwrite, 0);

      // WAW kill of an older queued entry
      pipe(1, 11, 32'h1111);
      lu(1, 10, 32'hAAAA);
      step();
      lu(0, 0, 0);
      pipe(1, 10, 32'hBBBB);
      check("waw_q_count", q_count, 1);
      step();
      pipe(0, 0, 0);
      check("waw_regwrite", regwrite, 1);
      check("waw_writereg", writereg, 10);
      check("waw_writedata", writedata, 32'hBBBB);
      step();
      check("waw_dead_regwrite", regwrite, 0);
      check("waw_dead_q_count", q_count, 0);
      check("waw_dead_data", writedata, 32'hBBBB);

      // WAW kill of an entry enqueued in the same cycle
      pipe(1, 12, 32'hC);
      lu(1, 12, 32'hCC);
      step();
      pipe(0, 0, 0);
      lu(0, 0, 0);
      check("wawsame_writereg", writereg, 12);
      check("wawsame_writedata", writedata, 32'hC);
      check("wawsame_q_count", q_count, 1);
      step();
      check("wawsame_regwrite", regwrite, 0);
      check("wawsame_q_empty", q_count, 0);

      // rd==0 is never written
      pipe(1, 0, 32'h5555);
      step();
      pipe(0, 0, 0);
      check("rd0_pipe_regwrite", regwrite, 0);
      lu(1, 0, 32'h6666);
      check("rd0_lu_ready", lu_ready, 1);
      step();
      lu(0, 0, 0);
      check("rd0_lu_regwrite", regwrite, 0);
      check("rd0_q_count", q_count, 0);

      // reset mid-drain
      pipe(1, 1, 32'h77);
      lu(1, 20, 32'h20);
      step();
      lu(1, 21, 32'h21);
      step();
      pipe(0, 0, 0);
      lu(0, 0, 0);
      check("prerst_q_count", q_count, 2);
      check("prerst_regwrite", regwrite, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_regwrite", regwrite, 0);
      check("midrst_writereg", writereg, 0);
      check("midrst_writedata", writedata, 0);
      check("midrst_q_count", q_count, 0);
      check("midrst_lu_ready", lu_ready, 1);
      check("midrst_stall", wb_stall_req, 0);
      step();
      rst_n = 1'b1;
      step();
      check("postrst_regwrite1", regwrite, 0);
      step();
      check("postrst_regwrite2", regwrite, 0);
      check("postrst_q_count", q_count, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
